rom_instr_prefetch: RTL and testbench

Instruction prefetch stage upstream of the ALU/decoder in the GSU core. It fetches opcode bytes from game ROM at `{pbr, pc}`, honours host bus arbitration and a fixed ROM wait-state count, and buffers bytes in a small first-word-fall-through queue. It presents bytes to decode with a valid/ready handshake and flushes on branch/jump redirects.

---
 rtl/rom_instr_prefetch_pkg.sv | 22 ++
 rtl/rom_instr_prefetch_fifo.sv | 66 ++++++
 rtl/rom_instr_prefetch.sv | 126 ++++++++++++
 tb/tb_rom_instr_prefetch.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rom_instr_prefetch_pkg.sv
// Shared definitions for the GSU instruction prefetch stage.
package rom_instr_prefetch_pkg;

    localparam int BANK_W   = 8;
    localparam int PC_W     = 16;
    localparam int OPCODE_W = 8;
    localparam int ENTRY_W  = OPCODE_W + PC_W;

    // Presented to decode whenever the queue is empty.
    localparam logic [OPCODE_W-1:0] NOP_OPCODE = 8'h01;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } fetch_state_t;

    // Fetch address increment; wraps within the bank.
    function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] a);
        return a + PC_W'(1);
    endfunction

endpackage

// File: rtl/rom_instr_prefetch_fifo.sv
// First-word-fall-through queue holding {opcode, address} entries.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 24,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop on an empty queue is ignored; a push into a full queue only lands
    // when a pop frees the slot in the same cycle.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

    // Pointer and occupancy bookkeeping; clear empties the queue outright.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
            else if (!do_push && do_pop) count_reg <= count_reg - CW'(1);
        end
    end

    // Storage entries; only the slot under the write pointer is updated.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture incoming entry into slot gi.
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PW'(gi))) mem[gi] <= din;
            end
        end
    endgenerate

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/rom_instr_prefetch.sv
// Instruction prefetch: ROM fetch FSM with wait states, grant handling,
// redirect flush and a FWFT opcode queue towards decode.
module rom_instr_prefetch
    import rom_instr_prefetch_pkg::*;
#(
    parameter int ROM_WAIT = 3,
    parameter int DEPTH    = 2
) (
    input  logic                  clk_21mhz,
    input  logic                  reset,
    input  logic                  go,
    input  logic [BANK_W-1:0]     pbr,
    input  logic                  redirect,
    input  logic [PC_W-1:0]       redirect_pc,
    input  logic                  rom_grant,
    input  logic [OPCODE_W-1:0]   rom_d,
    output logic                  rom_req,
    output logic [BANK_W+PC_W-1:0] rom_a,
    output logic [OPCODE_W-1:0]   instr,
    output logic [PC_W-1:0]       instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [PC_W-1:0]       pc
);

    localparam int WW = $clog2(ROM_WAIT + 1);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t           state_reg;
    fetch_state_t           state_next;
    logic [WW-1:0]          wait_cnt_reg;
    logic [PC_W-1:0]        pc_reg;
    logic [BANK_W+PC_W-1:0] rom_a_reg;
    logic                   rom_req_reg;

    logic                   complete;
    logic                   room;
    logic                   start;
    logic                   push;
    logic [ENTRY_W-1:0]     fifo_dout;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;

    // Next-state and control decode. Room is judged counting this cycle's
    // push but not this cycle's pop, so the queue can never overflow.
    always_comb begin
        state_next = state_reg;
        complete   = (state_reg == ACCESS) && rom_grant && (wait_cnt_reg == WW'(1));
        room       = complete ? (fifo_count < CW'(DEPTH - 1)) : !fifo_full;
        start      = go && !redirect && room;
        push       = complete && !redirect;
        case (state_reg)
            IDLE:    if (start) state_next = ACCESS;
            ACCESS:  if (complete && !start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (redirect) state_next = IDLE;
    end

    // FSM state register.
    always_ff @(posedge clk_21mhz) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Fetch datapath: address latch, request, wait counter and pc.
    always_ff @(posedge clk_21mhz) begin
        if (reset) begin
            pc_reg       <= '0;
            rom_a_reg    <= '0;
            rom_req_reg  <= 1'b0;
            wait_cnt_reg <= '0;
        end else if (redirect) begin
            pc_reg       <= redirect_pc;
            rom_req_reg  <= 1'b0;
            wait_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (start) begin
                rom_a_reg    <= {pbr, pc_reg};
                rom_req_reg  <= 1'b1;
                wait_cnt_reg <= WW'(ROM_WAIT);
            end
        end else begin
            if (!rom_grant) begin
                // Losing the bus restarts the access from scratch.
                wait_cnt_reg <= WW'(ROM_WAIT);
            end else if (complete) begin
                pc_reg <= pc_incr(pc_reg);
                if (start) begin
                    rom_a_reg    <= {pbr, pc_incr(pc_reg)};
                    wait_cnt_reg <= WW'(ROM_WAIT);
                end else begin
                    rom_req_reg  <= 1'b0;
                    wait_cnt_reg <= '0;
                end
            end else begin
                wait_cnt_reg <= wait_cnt_reg - WW'(1);
            end
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk_21mhz),
        .srst  (reset),
        .clear (redirect),
        .push  (push),
        .din   ({rom_d, rom_a_reg[PC_W-1:0]}),
        .pop   (instr_ready),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rom_req     = rom_req_reg;
    assign rom_a       = rom_a_reg;
    assign pc          = pc_reg;
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? NOP_OPCODE : fifo_dout[ENTRY_W-1:PC_W];
    assign instr_pc    = fifo_empty ? '0 : fifo_dout[PC_W-1:0];

endmodule

// File: tb/tb_rom_instr_prefetch.sv
// Directed bench for rom_instr_prefetch (ROM_WAIT=3, DEPTH=2).
module tb_rom_instr_prefetch;

    logic        clk_21mhz;
    logic        reset;
    logic        go;
    logic [7:0]  pbr;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        rom_grant;
    logic [7:0]  rom_d;
    logic        rom_req;
    logic [23:0] rom_a;
    logic [7:0]  instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc;

    int checks = 0;
    int errors = 0;

    rom_instr_prefetch #(
        .ROM_WAIT (3),
        .DEPTH    (2)
    ) dut (
        .clk_21mhz   (clk_21mhz),
        .reset       (reset),
        .go          (go),
        .pbr         (pbr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_grant   (rom_grant),
        .rom_d       (rom_d),
        .rom_req     (rom_req),
        .rom_a       (rom_a),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc)
    );

    initial clk_21mhz = 1'b0;
    always #5 clk_21mhz = ~clk_21mhz;

    // ROM contents: byte = low address byte + 8'hA0.
    assign rom_d = rom_a[7:0] + 8'hA0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_21mhz);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; pbr = 8'h01; redirect = 1'b0;
        redirect_pc = 16'h0000; rom_grant = 1'b1; instr_ready = 1'b0;
        steps(2);
        chk("rst_rom_req", 32'(rom_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", 32'(instr), 32'h01);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_rom_a", 32'(rom_a), 32'h0);

        // Cycle 1: start condition true.
        reset = 1'b0; go = 1'b1;
        steps(1); // cycle 2
        chk("fetch_req", 32'(rom_req), 32'h1);
        chk("fetch_addr", 32'(rom_a), 32'h010000);
        steps(2); // cycle 4
        chk("fetch_not_early", 32'(instr_valid), 32'h0);
        steps(1); // cycle 5
        $display("txn fetch: instr=%h instr_pc=%h valid=%b", instr, instr_pc, instr_valid);
        chk("fetch_valid", 32'(instr_valid), 32'h1);
        chk("fetch_instr", 32'(instr), 32'hA0);
        chk("fetch_instr_pc", 32'(instr_pc), 32'h0);
        chk("fetch2_addr", 32'(rom_a), 32'h010001);
        chk("fetch2_pc", 32'(pc), 32'h1);

        // Backpressure: queue fills with two bytes and fetching stops.
        steps(3); // cycle 8
        chk("bp_req_low", 32'(rom_req), 32'h0);
        chk("bp_pc", 32'(pc), 32'h2);
        chk("bp_head", 32'(instr), 32'hA0);
        steps(3); // cycle 11
        chk("bp_req_held_low", 32'(rom_req), 32'h0);
        chk("bp_still_valid", 32'(instr_valid), 32'h1);
        instr_ready = 1'b1;
        steps(1); // cycle 12
        $display("txn pop: instr=%h instr_pc=%h", instr, instr_pc);
        chk("bp_second", 32'(instr), 32'hA1);
        chk("bp_second_pc", 32'(instr_pc), 32'h1);
        steps(1); // cycle 13
        instr_ready = 1'b0;
        chk("bp_empty_nop", 32'(instr), 32'h01);
        chk("bp_empty_valid", 32'(instr_valid), 32'h0);
        chk("bp_resume_req", 32'(rom_req), 32'h1);
        chk("bp_resume_addr", 32'(rom_a), 32'h010002);
        steps(3); // cycle 16
        $display("txn resume: instr=%h instr_pc=%h", instr, instr_pc);
        chk("bp_third", 32'(instr), 32'hA2);
        chk("bp_third_pc", 32'(instr_pc), 32'h2);

        // Grant loss for 5 cycles mid-access of 0x010003.
        steps(1); // cycle 17
        rom_grant = 1'b0;
        steps(2); // cycle 19
        chk("gl_req_held", 32'(rom_req), 32'h1);
        chk("gl_addr_held", 32'(rom_a), 32'h010003);
        steps(3); // cycle 22
        rom_grant = 1'b1; instr_ready = 1'b1;
        steps(1); // cycle 23
        instr_ready = 1'b0;
        chk("gl_popped", 32'(instr_valid), 32'h0);
        steps(1); // cycle 24
        chk("gl_not_early", 32'(instr_valid), 32'h0);
        steps(1); // cycle 25
        $display("txn grant_loss: instr=%h instr_pc=%h", instr, instr_pc);
        chk("gl_byte", 32'(instr), 32'hA3);
        chk("gl_byte_pc", 32'(instr_pc), 32'h3);
        chk("gl_next_addr", 32'(rom_a), 32'h010004);

        // Redirect mid-access with a same-cycle pop.
        steps(1); // cycle 26
        redirect = 1'b1; redirect_pc = 16'h1234; instr_ready = 1'b1;
        steps(1); // cycle 27
        redirect = 1'b0; instr_ready = 1'b0;
        chk("rd_flush", 32'(instr_valid), 32'h0);
        chk("rd_req_low", 32'(rom_req), 32'h0);
        chk("rd_pc", 32'(pc), 32'h1234);
        steps(1); // cycle 28
        chk("rd_req", 32'(rom_req), 32'h1);
        chk("rd_addr", 32'(rom_a), 32'h011234);
        steps(2); // cycle 30
        chk("rd_no_stale", 32'(instr_valid), 32'h0);
        steps(1); // cycle 31
        $display("txn redirect: instr=%h instr_pc=%h", instr, instr_pc);
        chk("rd_byte", 32'(instr), 32'hD4);
        chk("rd_byte_pc", 32'(instr_pc), 32'h1234);

        // Wrap within bank 0x05.
        pbr = 8'h05; redirect = 1'b1; redirect_pc = 16'hFFFF;
        steps(1); // cycle 32
        redirect = 1'b0;
        chk("wr_pc", 32'(pc), 32'hFFFF);
        steps(1); // cycle 33
        chk("wr_addr_hi", 32'(rom_a), 32'h05FFFF);
        steps(3); // cycle 36
        $display("txn wrap: instr=%h instr_pc=%h rom_a=%h", instr, instr_pc, rom_a);
        chk("wr_byte", 32'(instr), 32'h9F);
        chk("wr_byte_pc", 32'(instr_pc), 32'hFFFF);
        chk("wr_addr_lo", 32'(rom_a), 32'h050000);
        chk("wr_pc_wrapped", 32'(pc), 32'h0000);
        instr_ready = 1'b1;
        steps(1); // cycle 37
        instr_ready = 1'b0;
        steps(2); // cycle 39
        $display("txn wrap2: instr=%h instr_pc=%h", instr, instr_pc);
        chk("wr_byte2", 32'(instr), 32'hA0);
        chk("wr_byte2_pc", 32'(instr_pc), 32'h0000);
        chk("wr_inflight", 32'(rom_req), 32'h1);

        // Reset mid-access with one byte queued.
        reset = 1'b1; go = 1'b0;
        steps(1); // cycle 40
        reset = 1'b0;
        chk("mr_req", 32'(rom_req), 32'h0);
        chk("mr_valid", 32'(instr_valid), 32'h0);
        chk("mr_instr", 32'(instr), 32'h01);
        chk("mr_pc", 32'(pc), 32'h0);
        chk("mr_rom_a", 32'(rom_a), 32'h0);
        steps(4);
        chk("mr_no_push", 32'(instr_valid), 32'h0);
        chk("mr_idle", 32'(rom_req), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
